// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare direction predictor with in-order snapshot FIFO and history repair on redirect
// ports: lk_valid/lk_pc in, lk_taken/lk_ready out (fetch lookup + snapshot push);
//        update/taken/branchjump_miss in (exec train, pop, flush); occupancy out (snapshots in flight)
module gshare_predictor #(
  parameter int INDEX_BITS = 8,
  parameter int GHR_BITS = 8,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic lk_valid,
  input  logic [31:0] lk_pc,
  output logic lk_ready,
  output logic lk_taken,
  input  logic update,
  input  logic taken,
  input  logic branchjump_miss,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int ENTRIES = 1 << INDEX_BITS;
  logic [1:0] ctr [ENTRIES];
  logic [INDEX_BITS-1:0] f_idx [DEPTH];
  logic [GHR_BITS-1:0] f_ghr [DEPTH];
  logic [GHR_BITS-1:0] ghr_spec, ghr_arch, arch_next;
  logic [PW-1:0] head, tail;
  logic [INDEX_BITS-1:0] idx, h_idx;
  logic [1:0] c, c_next;
  logic push, pop;
  logic unused_bits;
  always_comb begin
    idx = lk_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_spec);
    lk_taken = ctr[idx][1];
    lk_ready = occupancy != (PW+1)'(DEPTH);
    push = lk_valid && lk_ready && !branchjump_miss;
    pop = update && occupancy != '0;
    h_idx = f_idx[head];
    c = ctr[h_idx];
    c_next = taken ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
    arch_next = pop ? {ghr_arch[GHR_BITS-2:0], taken} : ghr_arch;
    unused_bits = ^{lk_pc[31:INDEX_BITS+2], lk_pc[1:0], f_ghr[head]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
      ghr_spec <= '0;
      ghr_arch <= '0;
      head <= '0;
      tail <= '0;
      occupancy <= '0;
    end else begin
      if (pop) ctr[h_idx] <= c_next;
      ghr_arch <= arch_next;
      if (branchjump_miss) begin
        head <= '0;
        tail <= '0;
        occupancy <= '0;
        ghr_spec <= arch_next;
      end else begin
        head <= head + PW'(pop);
        tail <= tail + PW'(push);
        occupancy <= occupancy + (PW+1)'(push) - (PW+1)'(pop);
        if (push) ghr_spec <= {ghr_spec[GHR_BITS-2:0], lk_taken};
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      f_idx[tail] <= idx;
      f_ghr[tail] <= ghr_spec;
    end
endmodule
